// File: rtl/dev_tape_io_pkg.sv
// ----------------------------------------------------------------------------
// dev_tape_io_pkg
// Shared device defines for the paper-tape emulator: the character width and
// the character type used on every tape-side and host-side data path.
// ----------------------------------------------------------------------------
package dev_tape_io_pkg;

   localparam int CHAR_W = 5;

   typedef logic [CHAR_W-1:0] char_t;

endpackage

// File: rtl/dev_tape_io_sync_fifo.sv
// ----------------------------------------------------------------------------
// sync_fifo
// Single-clock FIFO with show-ahead read. The head entry is always visible on
// `head` (forced to zero while empty). A push on a full FIFO is refused even if
// a pop happens in the same cycle. A pop on an empty FIFO is ignored.
//
// Ports:
//   clk, reset       : clock, synchronous active-high reset (empties FIFO)
//   push, push_data  : write request and data
//   pop              : consume the head entry
//   head             : current head entry (show-ahead)
//   full, empty      : occupancy flags
//   count            : occupancy, 0..DEPTH
// ----------------------------------------------------------------------------
module sync_fifo #(
   parameter int WIDTH = 5,
   parameter int DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_data,
   input  logic                     pop,
   output logic [WIDTH-1:0]         head,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [AW:0]      count_q, count_d;
   logic             push_ok, pop_ok;

   assign full  = (count_q == (AW+1)'(DEPTH));
   assign empty = (count_q == '0);
   assign count = count_q;
   // Gate the head so an empty FIFO never shows stale storage.
   assign head  = empty ? '0 : mem_q[rd_ptr_q];

   always_comb begin
      push_ok  = push && !full;
      pop_ok   = pop && !empty;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      // Pointers wrap naturally since DEPTH is a power of two.
      if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({push_ok, pop_ok})
         2'b10:   count_d = count_q + (AW+1)'(1);
         2'b01:   count_d = count_q - (AW+1)'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage needs no reset: the flags and head gating hide its contents.
   always_ff @(posedge clk) begin
      if (push_ok) mem_q[wr_ptr_q] <= push_data;
   end

endmodule

// File: rtl/dev_tape_io.sv
// ----------------------------------------------------------------------------
// dev_tape_io
// Paper-tape device emulator. A reader path moves host characters through a
// FIFO to the core's input handshake, paced by READ_GAP idle cycles per
// character. A punch path captures the core's output characters into a FIFO
// drained by the host, paced by PUNCH_GAP idle cycles after each release.
// DEPTH must be a power of two >= 2; READ_GAP and PUNCH_GAP must be >= 1.
//
// Ports:
//   clk, reset                       : clock, synchronous active-high reset
//   host_rd_data/val/rdy             : host -> reader FIFO stream
//   dev_input_rdy                    : core waiting for an input character
//   dev_input_val, dev_input_data    : one-cycle strobe + held character
//   dev_output_rdy, dev_output_data  : core presenting an output character
//   dev_output_ack                   : one-cycle capture acknowledge
//   host_pu_data/val/rdy             : punch FIFO -> host stream (show-ahead)
//   rd_starved                       : core waiting on an empty reader FIFO
//   rd_count, pu_count               : FIFO occupancies
// ----------------------------------------------------------------------------
module dev_tape_io
   import dev_tape_io_pkg::*;
#(
   parameter int DEPTH     = 16,
   parameter int READ_GAP  = 4,
   parameter int PUNCH_GAP = 4
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [CHAR_W-1:0]      host_rd_data,
   input  logic                   host_rd_val,
   output logic                   host_rd_rdy,
   input  logic                   dev_input_rdy,
   output logic                   dev_input_val,
   output logic [CHAR_W-1:0]      dev_input_data,
   input  logic                   dev_output_rdy,
   input  logic [CHAR_W-1:0]      dev_output_data,
   output logic                   dev_output_ack,
   output logic [CHAR_W-1:0]      host_pu_data,
   output logic                   host_pu_val,
   input  logic                   host_pu_rdy,
   output logic                   rd_starved,
   output logic [$clog2(DEPTH):0] rd_count,
   output logic [$clog2(DEPTH):0] pu_count
);

   localparam int RGW = $clog2(READ_GAP + 1);
   localparam int PGW = $clog2(PUNCH_GAP + 1);

   typedef enum logic [1:0] {R_IDLE, R_PRESENT, R_GAP} r_state_t;
   typedef enum logic [1:0] {P_IDLE, P_ACK, P_WAITLOW, P_GAP} p_state_t;

   // ---------------------------------------------------------------- FIFOs
   char_t rd_head, pu_head;
   logic  rd_full, rd_empty, rd_pop;
   logic  pu_full, pu_empty, pu_push;

   assign host_rd_rdy = !rd_full && !reset;

   sync_fifo #(.WIDTH(CHAR_W), .DEPTH(DEPTH)) u_rd_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (host_rd_val && host_rd_rdy),
      .push_data (host_rd_data),
      .pop       (rd_pop),
      .head      (rd_head),
      .full      (rd_full),
      .empty     (rd_empty),
      .count     (rd_count)
   );

   sync_fifo #(.WIDTH(CHAR_W), .DEPTH(DEPTH)) u_pu_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (pu_push),
      .push_data (dev_output_data),
      .pop       (host_pu_rdy),
      .head      (pu_head),
      .full      (pu_full),
      .empty     (pu_empty),
      .count     (pu_count)
   );

   assign host_pu_data = pu_head;
   assign host_pu_val  = !pu_empty;

   // --------------------------------------------------------------- reader
   r_state_t         r_state_q, r_state_d;
   logic [RGW-1:0]   r_gap_q, r_gap_d;
   char_t            in_data_q, in_data_d;
   logic             starved_q, starved_d;

   always_comb begin
      r_state_d = r_state_q;
      r_gap_d   = r_gap_q;
      in_data_d = in_data_q;
      starved_d = 1'b0;
      rd_pop    = 1'b0;
      case (r_state_q)
         R_IDLE: begin
            starved_d = dev_input_rdy && rd_empty;
            if (dev_input_rdy && !rd_empty) begin
               rd_pop    = 1'b1;
               in_data_d = rd_head;
               r_state_d = R_PRESENT;
            end
         end
         R_PRESENT: begin
            // Gap lasts READ_GAP cycles: load N-1 and leave on zero.
            r_gap_d   = RGW'(READ_GAP - 1);
            r_state_d = R_GAP;
         end
         R_GAP: begin
            if (r_gap_q == '0) r_state_d = R_IDLE;
            else               r_gap_d   = r_gap_q - RGW'(1);
         end
         default: r_state_d = R_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state_q <= R_IDLE;
         r_gap_q   <= '0;
         in_data_q <= '0;
         starved_q <= 1'b0;
      end else begin
         r_state_q <= r_state_d;
         r_gap_q   <= r_gap_d;
         in_data_q <= in_data_d;
         starved_q <= starved_d;
      end
   end

   assign dev_input_val  = (r_state_q == R_PRESENT);
   assign dev_input_data = in_data_q;
   assign rd_starved     = starved_q;

   // ---------------------------------------------------------------- punch
   p_state_t         p_state_q, p_state_d;
   logic [PGW-1:0]   p_gap_q, p_gap_d;

   always_comb begin
      p_state_d = p_state_q;
      p_gap_d   = p_gap_q;
      pu_push   = 1'b0;
      case (p_state_q)
         P_IDLE: begin
            // When full the ack is withheld; the core keeps its level high.
            if (dev_output_rdy && !pu_full) begin
               pu_push   = 1'b1;
               p_state_d = P_ACK;
            end
         end
         P_ACK: p_state_d = P_WAITLOW;
         P_WAITLOW: begin
            // A held level must drop before the next capture is armed.
            if (!dev_output_rdy) begin
               p_gap_d   = PGW'(PUNCH_GAP - 1);
               p_state_d = P_GAP;
            end
         end
         P_GAP: begin
            if (p_gap_q == '0) p_state_d = P_IDLE;
            else               p_gap_d   = p_gap_q - PGW'(1);
         end
         default: p_state_d = P_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         p_state_q <= P_IDLE;
         p_gap_q   <= '0;
      end else begin
         p_state_q <= p_state_d;
         p_gap_q   <= p_gap_d;
      end
   end

   assign dev_output_ack = (p_state_q == P_ACK);

endmodule

// File: tb/tb_dev_tape_io.sv
module tb_dev_tape_io;

   localparam int DEPTH = 16;
   localparam int RG    = 4;
   localparam int PG    = 4;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [4:0] host_rd_data = '0;
   logic       host_rd_val = 1'b0;
   logic       host_rd_rdy;
   logic       dev_input_rdy = 1'b0;
   logic       dev_input_val;
   logic [4:0] dev_input_data;
   logic       dev_output_rdy = 1'b0;
   logic [4:0] dev_output_data = '0;
   logic       dev_output_ack;
   logic [4:0] host_pu_data;
   logic       host_pu_val;
   logic       host_pu_rdy = 1'b0;
   logic       rd_starved;
   logic [4:0] rd_count;
   logic [4:0] pu_count;

   dev_tape_io #(.DEPTH(DEPTH), .READ_GAP(RG), .PUNCH_GAP(PG)) dut (
      .clk(clk), .reset(reset),
      .host_rd_data(host_rd_data), .host_rd_val(host_rd_val), .host_rd_rdy(host_rd_rdy),
      .dev_input_rdy(dev_input_rdy), .dev_input_val(dev_input_val), .dev_input_data(dev_input_data),
      .dev_output_rdy(dev_output_rdy), .dev_output_data(dev_output_data), .dev_output_ack(dev_output_ack),
      .host_pu_data(host_pu_data), .host_pu_val(host_pu_val), .host_pu_rdy(host_pu_rdy),
      .rd_starved(rd_starved), .rd_count(rd_count), .pu_count(pu_count)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;
   int ack_seen = 0;

   // Reference model: FIFO contents as queues, pacing as absolute cycle times.
   int         cyc = 0;
   logic [4:0] rq[$];
   logic [4:0] pq[$];
   logic [4:0] r_data = '0;
   int         r_val_cyc = -1;
   int         r_idle_at = 0;
   bit         starved = 0;
   int         p_ack_cyc = -1;
   int         p_idle_at = 0;
   bit         p_wait = 0;
   int         p_wait_from = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   // Advance the model over the coming edge using the current inputs,
   // clock the DUT, then compare every output against the model.
   task automatic tick();
      int rsz = rq.size();
      int psz = pq.size();
      bit r_push, r_pop, p_push, p_pop;
      if (reset) begin
         rq.delete(); pq.delete();
         r_data = '0; r_val_cyc = -1; r_idle_at = 0; starved = 0;
         p_ack_cyc = -1; p_idle_at = 0; p_wait = 0;
      end else begin
         r_push  = host_rd_val && (rsz < DEPTH);
         r_pop   = (cyc >= r_idle_at) && dev_input_rdy && (rsz > 0);
         starved = (cyc >= r_idle_at) && dev_input_rdy && (rsz == 0);
         if (r_pop) begin
            r_data    = rq.pop_front();
            r_val_cyc = cyc + 1;
            r_idle_at = cyc + 2 + RG;
         end
         if (r_push) rq.push_back(host_rd_data);
         p_push = !p_wait && (cyc >= p_idle_at) && dev_output_rdy && (psz < DEPTH);
         p_pop  = host_pu_rdy && (psz > 0);
         if (p_wait && cyc >= p_wait_from && !dev_output_rdy) begin
            p_wait    = 0;
            p_idle_at = cyc + 1 + PG;
         end
         if (p_pop) void'(pq.pop_front());
         if (p_push) begin
            pq.push_back(dev_output_data);
            p_ack_cyc   = cyc + 1;
            p_wait      = 1;
            p_wait_from = cyc + 2;
         end
      end
      @(posedge clk);
      #1;
      cyc++;
      if (dev_output_ack === 1'b1) ack_seen++;
      chk("in_val",   dev_input_val,  (cyc == r_val_cyc));
      chk("in_data",  dev_input_data, r_data);
      chk("rd_count", rd_count,       rq.size());
      chk("pu_count", pu_count,       pq.size());
      chk("pu_val",   host_pu_val,    (pq.size() != 0));
      chk("pu_data",  host_pu_data,   (pq.size() != 0) ? pq[0] : 5'd0);
      chk("ack",      dev_output_ack, (cyc == p_ack_cyc));
      chk("rd_rdy",   host_rd_rdy,    (!reset && rq.size() < DEPTH));
      chk("starved",  rd_starved,     starved);
   endtask

   initial begin
      int n;
      // Reset state
      reset = 1'b1;
      repeat (2) tick();
      chk("rst_val", dev_input_val, 0);
      chk("rst_rdy", host_rd_rdy, 0);
      reset = 1'b0;
      tick();
      chk("rdy_after_rst", host_rd_rdy, 1);

      // Two reader characters, paced by READ_GAP
      dev_input_rdy = 1'b1;
      host_rd_val = 1'b1; host_rd_data = 5'h13; tick();
      host_rd_data = 5'h07; tick();
      host_rd_val = 1'b0;
      chk("t1_val0", dev_input_val, 1);
      chk("t1_dat0", dev_input_data, 5'h13);
      repeat (6) tick();
      chk("t1_val1", dev_input_val, 1);
      chk("t1_dat1", dev_input_data, 5'h07);
      repeat (3) tick();
      chk("t1_cnt", rd_count, 0);

      // Starvation
      repeat (3) tick();
      chk("t2_starved", rd_starved, 1);
      chk("t2_noval", dev_input_val, 0);
      host_rd_val = 1'b1; host_rd_data = 5'h1F; tick();
      host_rd_val = 1'b0; tick();
      chk("t2_val", dev_input_val, 1);
      chk("t2_dat", dev_input_data, 5'h1F);
      chk("t2_unstarved", rd_starved, 0);
      dev_input_rdy = 1'b0;

      // Held output level gives one capture
      dev_output_rdy = 1'b1; dev_output_data = 5'h0A; ack_seen = 0;
      repeat (10) tick();
      chk("t3_acks", ack_seen, 1);
      chk("t3_cnt", pu_count, 1);
      chk("t3_data", host_pu_data, 5'h0A);
      dev_output_rdy = 1'b0; host_pu_rdy = 1'b1; tick();
      host_pu_rdy = 1'b0; repeat (PG + 2) tick();

      // Fill punch FIFO, then back-pressure
      for (int i = 0; i < DEPTH; i++) begin
         dev_output_data = 5'(i); dev_output_rdy = 1'b1;
         ack_seen = 0; n = 0;
         while (ack_seen == 0 && n < 20) begin tick(); n++; end
         chk("t4_fill_ack", ack_seen, 1);
         dev_output_rdy = 1'b0;
         repeat (PG + 2) tick();
      end
      chk("t4_full", pu_count, DEPTH);
      dev_output_data = 5'h1B; dev_output_rdy = 1'b1; ack_seen = 0;
      repeat (5) tick();
      chk("t4_no_ack", ack_seen, 0);
      host_pu_rdy = 1'b1; tick();
      host_pu_rdy = 1'b0;
      chk("t4_ack_early", dev_output_ack, 0);
      tick();
      chk("t4_ack", dev_output_ack, 1);
      chk("t4_refill", pu_count, DEPTH);
      dev_output_rdy = 1'b0; host_pu_rdy = 1'b1;
      repeat (DEPTH + 4) tick();
      host_pu_rdy = 1'b0;

      // Fill reader FIFO, then push+pop in one cycle
      host_rd_val = 1'b1;
      for (int i = 0; i < DEPTH; i++) begin host_rd_data = 5'(i + 3); tick(); end
      chk("t5_full", rd_count, DEPTH);
      chk("t5_rdy", host_rd_rdy, 0);
      host_rd_data = 5'h1E; dev_input_rdy = 1'b1; tick();
      host_rd_val = 1'b0; dev_input_rdy = 1'b0;
      chk("t5_cnt", rd_count, DEPTH - 1);

      // Reset during R_PRESENT / P_ACK
      reset = 1'b1; tick(); reset = 1'b0;
      host_rd_val = 1'b1; host_rd_data = 5'h05; dev_input_rdy = 1'b1; tick();
      host_rd_val = 1'b0; dev_output_rdy = 1'b1; dev_output_data = 5'h09; tick();
      chk("t6_present", dev_input_val, 1);
      chk("t6_ackst", dev_output_ack, 1);
      reset = 1'b1; tick();
      chk("t6_val", dev_input_val, 0);
      chk("t6_data", dev_input_data, 0);
      chk("t6_ack", dev_output_ack, 0);
      chk("t6_puval", host_pu_val, 0);
      chk("t6_rdcnt", rd_count, 0);
      chk("t6_pucnt", pu_count, 0);
      reset = 1'b0; dev_input_rdy = 1'b0; dev_output_rdy = 1'b0;
      tick();

      // Randomized traffic against the model
      for (int i = 0; i < 3000; i++) begin
         reset           = ($urandom_range(0, 399) == 0);
         host_rd_val     = $urandom_range(0, 1) != 0;
         host_rd_data    = 5'($urandom);
         dev_input_rdy   = $urandom_range(0, 3) != 0;
         if ($urandom_range(0, 3) == 0) dev_output_rdy = !dev_output_rdy;
         dev_output_data = 5'($urandom);
         host_pu_rdy     = $urandom_range(0, 2) == 0;
         tick();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
